// File: rtl/histeq_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : histeq_bank_scheduler
// Purpose  : Ping-pong frame scheduler for histogram equalisation. One bank
//            accumulates the current frame while the other supplies the LUT
//            built from the previous frame; between frames it requests the
//            CDF/LUT build, swaps banks and clears the new accumulate bank.
// Revision : 1.0 - initial handshake-based release
// ============================================================================
module histeq_bank_scheduler #(
  parameter int IMAGE_SIZE  = 640*480,
  parameter int CDF_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_pixel_valid,
  output logic       o_pix_ready,
  output logic       o_acc_en,
  output logic       o_acc_bank,
  output logic       o_lut_bank,
  output logic       o_lut_valid,
  output logic       o_cdf_start,
  output logic       o_cdf_bank,
  input  logic       i_cdf_done,
  output logic       o_clr_en,
  output logic [7:0] o_clr_addr,
  output logic       o_frame_done,
  output logic       o_overrun,
  output logic       o_cdf_timeout,
  input  logic       i_err_clear
);

  localparam int c_cnt_w = $clog2(IMAGE_SIZE);
  localparam int c_tmr_w = $clog2(CDF_TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(IMAGE_SIZE - 1);
  localparam logic [c_tmr_w-1:0] c_last_tmr = c_tmr_w'(CDF_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_READY    = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_CDF_REQ  = 3'd3,
    ST_CDF_WAIT = 3'd4
  } state_t;

  state_t               state_q,       state_d;
  logic [7:0]           clr_addr_q,    clr_addr_d;
  logic                 acc_bank_q,    acc_bank_d;
  logic                 lut_valid_q,   lut_valid_d;
  logic [c_cnt_w-1:0]   count_q,       count_d;
  logic [c_tmr_w-1:0]   timer_q,       timer_d;
  logic                 frame_done_q,  frame_done_d;
  logic                 overrun_q,     overrun_d;
  logic                 cdf_timeout_q, cdf_timeout_d;

  logic                 pix_ready;
  logic                 pix_accept;

  // Pixel handshake decoded straight from state so ready drops the cycle after the last pixel.
  always_comb begin
    pix_ready  = ((state_q == ST_READY) && i_enable) || (state_q == ST_ACCUM);
    pix_accept = i_pixel_valid && pix_ready;
  end

  // Next-state, counters, bank swap and sticky error flags.
  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    acc_bank_d    = acc_bank_q;
    lut_valid_d   = lut_valid_q;
    count_d       = count_q;
    timer_d       = timer_q;
    frame_done_d  = 1'b0;
    // A new set beats a simultaneous clear.
    overrun_d     = (overrun_q && !i_err_clear) || (i_pixel_valid && !pix_ready);
    cdf_timeout_d = cdf_timeout_q && !i_err_clear;

    case (state_q)
      ST_CLEAR: begin
        // Address wraps back to 0 after 255, ready for the next sweep.
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (pix_accept) begin
          state_d = ST_ACCUM;
          count_d = c_cnt_w'(1);
        end
      end
      ST_ACCUM: begin
        if (pix_accept) begin
          if (count_q == c_last_pix) begin
            state_d = ST_CDF_REQ;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_CDF_REQ: begin
        timer_d = '0;
        state_d = ST_CDF_WAIT;
      end
      ST_CDF_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (i_cdf_done) begin
          // The freshly built bank becomes the LUT; the old LUT bank is cleared next.
          acc_bank_d   = !acc_bank_q;
          lut_valid_d  = 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_CLEAR;
        end else if (timer_q == c_last_tmr) begin
          // Abort: keep the banks, mark the LUT unusable and re-clear the same bank.
          cdf_timeout_d = 1'b1;
          lut_valid_d   = 1'b0;
          frame_done_d  = 1'b1;
          state_d       = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any frame in progress.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= 8'd0;
      acc_bank_q    <= 1'b0;
      lut_valid_q   <= 1'b0;
      count_q       <= '0;
      timer_q       <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      cdf_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      acc_bank_q    <= acc_bank_d;
      lut_valid_q   <= lut_valid_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      cdf_timeout_q <= cdf_timeout_d;
    end
  end

  // The LUT bank is always the complement of the accumulate bank, so they can never collide.
  always_comb begin
    o_pix_ready   = pix_ready;
    o_acc_en      = pix_accept;
    o_acc_bank    = acc_bank_q;
    o_lut_bank    = !acc_bank_q;
    o_lut_valid   = lut_valid_q;
    o_cdf_start   = (state_q == ST_CDF_REQ);
    o_cdf_bank    = acc_bank_q;
    o_clr_en      = (state_q == ST_CLEAR);
    o_clr_addr    = clr_addr_q;
    o_frame_done  = frame_done_q;
    o_overrun     = overrun_q;
    o_cdf_timeout = cdf_timeout_q;
  end

endmodule
`default_nettype wire
